// File: rtl/dig_scan_ctrl_pkg.sv
// dig_scan_ctrl_pkg: register offsets, FSM encoding and default timing for the digit scanner
package dig_scan_ctrl_pkg;
  localparam int SCAN_DIV_DEF = 25000;
  localparam int BLANK_CYC_DEF = 250;
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
`ifdef DIG_LZB_EN
  // digit i>0 is blank when it and every higher nibble are zero
  function automatic logic lz_blank(input logic [31:0] d, input logic [2:0] i);
    return i != 3'd0 && (d >> {i, 2'b00}) == 32'd0;
  endfunction
`endif
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: hex nibble to active-low {G,F,E,D,C,B,A} segments
module seg7_decode (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end
endmodule

// File: rtl/dig_scan_ctrl.sv
// dig_scan_ctrl: bus-programmed 8-digit multiplexed 7-segment scanner with per-slot blanking.
// Define DIG_LZB_EN to add leading-zero blanking.
module dig_scan_ctrl
  import dig_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [31:0] data;
  logic [7:0] mask, dp;
  logic en, lit;
  state_t state, state_n;
  logic [2:0] idx, idx_n;
  logic [DW-1:0] div, div_n;
  logic [3:0] nib;
  logic [6:0] hex;
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};
  always_comb begin
    state_n = state;
    idx_n = idx;
    div_n = div + DW'(1);
    if (!en || state == IDLE) begin
      state_n = en ? BLANK : IDLE;
      idx_n = 3'd0;
      div_n = '0;
    end else if (state == BLANK && div == DW'(BLANK_CYC - 1)) begin
      state_n = SHOW;
    end else if (state == SHOW && div == DW'(SCAN_DIV - 1)) begin
      state_n = BLANK;
      idx_n = idx + 3'd1;
      div_n = '0;
    end
  end
  // outputs are decoded from the next state so they stay aligned with the FSM registers
  assign nib = data[{idx_n, 2'b00} +: 4];
`ifdef DIG_LZB_EN
  assign lit = mask[idx_n] && !lz_blank(data, idx_n);
`else
  assign lit = mask[idx_n];
`endif
  seg7_decode u_dec (.nib(nib), .seg(hex));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      mask <= 8'hFF;
      dp <= '0;
      en <= 1'b1;
      state <= BLANK;
      idx <= '0;
      div <= '0;
      dig_en <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      if (wen && addr[3:2] == A_DATA) data <= wdata;
      if (wen && addr[3:2] == A_MASK) {dp, mask} <= wdata[15:0];
      if (wen && addr[3:2] == A_CTRL) en <= wdata[0];
      state <= state_n;
      idx <= idx_n;
      div <= div_n;
      dig_en <= (state_n == SHOW && lit) ? ~(8'd1 << idx_n) : 8'hFF;
      seg <= state_n == SHOW ? {~dp[idx_n], hex} : 8'hFF;
    end
  end
endmodule

// File: tb/tb_dig_scan_ctrl.sv
// tb_dig_scan_ctrl: scoreboarded directed test of dig_scan_ctrl with SCAN_DIV=4, BLANK_CYC=1
module tb_dig_scan_ctrl;
  typedef struct {
    logic [7:0] de;
    logic [7:0] sg;
    bit cs;
    int n;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] addr = '0;
  logic wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [7:0] dig_en, seg;
  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int nstep = 0;
  dig_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata),
    .dig_en(dig_en), .seg(seg)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (dig_en !== e.de || (e.cs && seg !== e.sg)) begin
        bad++;
        $display("FAIL step%0d: dig_en=%h seg=%h expected dig_en=%h seg=%h%s",
                 e.n, dig_en, seg, e.de, e.sg, e.cs ? "" : " (seg not checked)");
      end
    end
  end
  task automatic step(input logic [7:0] de, input logic [7:0] sg, input bit cs = 1'b1);
    exp_t x;
    x.de = de;
    x.sg = sg;
    x.cs = cs;
    x.n = nstep++;
    sb.push_back(x);
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = {28'd0, a, 2'b00};
    wdata = d;
    wen = 1'b1;
  endtask
  // one slot: a blank cycle then three lit cycles; optional write lands on the closing edge
  task automatic slot(input logic [7:0] de, input logic [7:0] sg, input bit cs = 1'b1,
                      input bit w = 1'b0, input logic [1:0] a = 2'd0, input logic [31:0] d = '0);
    step(8'hFF, 8'hFF);
    step(de, sg, cs);
    step(de, sg, cs);
    if (w) wr(a, d);
    step(de, sg, cs);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end
  initial begin
    @(posedge clk);
    #1;
    step(8'hFF, 8'hFF);
    step(8'hFF, 8'hFF);
    rst = 1'b0;
    slot(8'hFE, 8'hC0);
    step(8'hFF, 8'hFF);
    step(8'hFD, 8'hC0);
    rst = 1'b1;
    step(8'hFF, 8'hFF);
    rst = 1'b0;
    slot(8'hFE, 8'hC0, 1, 1, 2'd0, 32'h12345678);
    slot(8'hFD, 8'hF8);
    slot(8'hFB, 8'h82);
    slot(8'hF7, 8'h92);
    slot(8'hEF, 8'h99);
    slot(8'hDF, 8'hB0);
    slot(8'hBF, 8'hA4);
    slot(8'h7F, 8'hF9);
    slot(8'hFE, 8'h80, 1, 1, 2'd1, 32'h0000040F);
    slot(8'hFD, 8'hF8);
    slot(8'hFB, 8'h02);
    slot(8'hF7, 8'h92);
    slot(8'hFF, 8'h99);
    slot(8'hFF, 8'hB0);
    slot(8'hFF, 8'hA4);
    slot(8'hFF, 8'hF9, 1, 1, 2'd1, 32'h000000FF);
    slot(8'hFE, 8'h80);
    slot(8'hFD, 8'hF8);
    slot(8'hFB, 8'h82);
    slot(8'hF7, 8'h92);
    slot(8'hEF, 8'h99);
    step(8'hFF, 8'hFF);
    wr(2'd2, 32'd0);
    step(8'hDF, 8'hB0);
    step(8'hDF, 8'hB0);
    repeat (20) step(8'hFF, 8'hFF);
    wr(2'd2, 32'd1);
    step(8'hFF, 8'hFF);
    step(8'hFF, 8'hFF);
    step(8'hFF, 8'hFF);
    step(8'hFE, 8'h80);
    wr(2'd2, 32'd1);
    step(8'hFE, 8'h80);
    step(8'hFE, 8'h80);
    slot(8'hFD, 8'hF8, 1, 1, 2'd0, 32'h12345F78);
`ifdef DIG_LZB_EN
    slot(8'hFB, 8'h8E, 1, 1, 2'd0, 32'h00000A05);
    repeat (5) slot(8'hFF, 8'hFF, 0);
    slot(8'hFE, 8'h92);
    slot(8'hFD, 8'hC0);
    slot(8'hFB, 8'h88, 1, 1, 2'd0, 32'd0);
    repeat (5) slot(8'hFF, 8'hFF, 0);
    slot(8'hFE, 8'hC0);
    slot(8'hFF, 8'hFF, 0);
    slot(8'hFF, 8'hFF, 0);
`else
    slot(8'hFB, 8'h8E);
    slot(8'hF7, 8'h92);
`endif
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
